axi_burst_master: RTL
=====================

Name: axi_burst_master

Overview:
- AXI4 initiator that converts a simple command/stream interface into single AXI4 INCR bursts of 32-bit words.
- Sits between the DSP/FIFO datapath and the external memory.
- Drives the memory controller in hardware, or the AXI memory behavioural model in simulation.
- One transaction outstanding at a time, either read or write.

Parameters:
- addr_width, 32, byte address width of cmd_addr and axaddr.
- max_len, 256, maximum beats per burst (AXI4 limit).
- axi_id, 0, constant ID driven on awid/arid.

Ports:
- aclk  input  1  clock for all logic.
- areset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  addr_width  byte address; must be 4-byte aligned.
- cmd_len  input  9  beats, 1..max_len.
- wr_data  input  32  write stream data.
- wr_valid  input  1  write stream valid.
- wr_ready  output  1  write stream ready.
- rd_data  output  32  read stream data.
- rd_valid  output  1  read stream valid.
- rd_ready  input  1  read stream ready.
- done  output  1  one-cycle pulse when a transaction completes.
- err  output  1  one-cycle pulse: bad command, or error response.
- axi  AXI4_Std.master  -  AXI4 port, 32-bit data.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All AXI valid/ready outputs 0: awvalid, wvalid, wlast, bready, arvalid, rready.
  - cmd_ready=0, done=0, err=0, beat counter 0.
  - Registered address/length 0.
  - A reset mid-burst abandons the burst with no completion.
- Constant AXI fields: axsize=3'b010, axburst=INCR, wstrb=4'hF, ids=axi_id.
- States: IDLE, AW, W, B, AR, R.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr and len.
  - Alignment/range check: cmd_len==0, cmd_len>max_len, cmd_addr[1:0]!=0, or the burst crossing a 4 KB boundary (addr[11:0]+4*len > 4096) -> err pulse next cycle, stay IDLE, no AXI activity.
  - Otherwise go to AW if cmd_write, else AR.
- AW:
  - awvalid=1, awaddr=latched addr, awlen=len-1.
  - awvalid must stay asserted and stable until awready.
  - On awvalid && awready -> W.
- W:
  - wvalid=wr_valid, wdata=wr_data, wr_ready=wready; both are combinational passthroughs gated by state==W.
  - wlast=1 when beat counter == len-1.
  - The counter increments on each wvalid && wready.
  - On the last beat handshake -> B.
  - A stalled wr_valid is legal; it simply delays the burst.
- B:
  - bready=1.
  - On bvalid: bresp[1]=1 (SLVERR/DECERR) -> err pulse; OKAY and EXOKAY are success.
  - done pulses in either case; go to IDLE.
- AR:
  - arvalid/araddr/arlen held stable until arready.
  - On handshake -> R.
- R:
  - rready=rd_ready, rd_valid=rvalid, rd_data=rdata (passthrough).
  - Count beats on rvalid && rready.
  - Any beat with rresp[1]=1 sets a sticky error flag.
  - On the beat where counter==len-1, or rlast, -> done pulse, plus an err pulse if the sticky flag is set; go to IDLE and clear the flag.
  - rlast arriving early or late relative to the counter -> err pulse. Completion follows whichever of rlast or the counter comes first.
- cmd_ready is 0 in every state except IDLE, so back-to-back commands incur a one-cycle IDLE gap.
- done and err are registered and are never high for more than one cycle.

Decomposition:
- Shared package axi_pkg holds:
  - typedef for the state enum.
  - Constants AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00, AXI_RESP_EXOKAY=2'b01.
  - Constant AXI_4K_BOUNDARY=4096.
- No sub-module; a single FSM plus beat counter is natural.
- Bench pairs this block with the AXI memory behavioural model as the slave.

Test Plan:
- Write then read: write addr 0x100, len 4, data 0xA0..0xA3; read addr 0x100, len 4 -> rd_data 0xA0,0xA1,0xA2,0xA3; wlast only on beat 4; one done pulse per transaction; no err (EXOKAY bresp accepted).
- Backpressure: wr_valid toggled every other cycle on a len-16 write; then rd_ready deasserted for 5 cycles mid-read -> no beats lost or duplicated; readback matches 16 words.
- Illegal commands: cmd_len=0, addr=0x2, and addr=0xFF8 with len 4 (crosses 4 KB) -> err pulse each time; awvalid/arvalid never asserted.
- Max burst: len 256 at 0x1000 -> awlen=255; 256 beats; wlast only on beat 256; readback identical.
- Error response: force bresp=2'b10 -> err and done pulse in the same cycle; FSM returns to IDLE and accepts the next command.
- Reset mid-operation: assert areset during W beat 3 of 8 -> all AXI valids 0 immediately (asynchronous); after release cmd_ready=1 and a new len-2 write/read completes correctly.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the burst-master state encoding.
package axi_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_EXOKAY = 2'b01;
  localparam int unsigned AXI_4K_BOUNDARY = 4096;
  localparam int unsigned AXI_ID_W        = 4;
endpackage

// File: rtl/axi4_std.sv
// AXI4 bundle with 32-bit data; master/slave modports.
interface AXI4_Std
  import axi_pkg::*;
#(
  parameter int unsigned addr_width = 32
) ();
  logic [AXI_ID_W-1:0]   awid;
  logic [addr_width-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [AXI_ID_W-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AXI_ID_W-1:0]   arid;
  logic [addr_width-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_ID_W-1:0]   rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Command/stream to single-outstanding AXI4 INCR burst initiator (32-bit beats).
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int unsigned addr_width = 32,
  parameter int unsigned max_len    = 256,
  parameter int unsigned axi_id     = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [8:0]            cmd_len,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  err,
  AXI4_Std.master               axi
);
  state_t                state;
  logic [addr_width-1:0] addr_q;
  logic [8:0]            len_q;
  logic [8:0]            beat_cnt;
  logic [8:0]            last_idx;
  logic                  rd_err_q;
  logic                  cmd_accept;
  logic                  cmd_bad;
  logic                  w_hs;
  logic                  r_hs;
  logic                  last_beat;
  logic [13:0]           end_offset;

  // Offset of the byte just past the burst within its 4 KB page.
  assign end_offset = {2'b00, cmd_addr[11:0]} + {3'b000, cmd_len, 2'b00};
  assign cmd_bad    = (cmd_len == 9'd0) || (32'(cmd_len) > max_len) ||
                      (cmd_addr[1:0] != 2'b00) ||
                      (end_offset > 14'(AXI_4K_BOUNDARY));
  assign cmd_accept = cmd_valid && cmd_ready;
  assign last_idx   = len_q - 9'd1;
  assign last_beat  = (beat_cnt == last_idx);
  assign w_hs       = axi.wvalid && axi.wready;
  assign r_hs       = axi.rvalid && axi.rready;

  assign axi.awid    = AXI_ID_W'(axi_id);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = last_idx[7:0];
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = (state == AW);
  assign axi.wdata   = wr_data;
  assign axi.wstrb   = 4'hF;
  assign axi.wvalid  = (state == W) && wr_valid;
  assign axi.wlast   = (state == W) && last_beat;
  assign wr_ready    = (state == W) && axi.wready;
  assign axi.bready  = (state == B);
  assign axi.arid    = AXI_ID_W'(axi_id);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = last_idx[7:0];
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = (state == AR);
  assign axi.rready  = (state == R) && rd_ready;
  assign rd_valid    = (state == R) && axi.rvalid;
  assign rd_data     = axi.rdata;

  // cmd_ready is registered: it rises on the cycle the FSM lands in IDLE.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      rd_err_q  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            if (cmd_bad) err   <= 1'b1;
            else         state <= cmd_write ? AW : AR;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        AW: if (axi.awready) state <= W;
        W: begin
          if (w_hs) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= B;
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        B: begin
          if (axi.bvalid) begin
            done      <= 1'b1;
            err       <= axi.bresp[1];
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        AR: if (axi.arready) state <= R;
        R: begin
          if (r_hs) begin
            // Finish on whichever of rlast / counter comes first; disagreement is an error.
            if (last_beat || axi.rlast) begin
              done      <= 1'b1;
              err       <= rd_err_q | axi.rresp[1] | (last_beat != axi.rlast);
              rd_err_q  <= 1'b0;
              beat_cnt  <= '0;
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
              rd_err_q <= rd_err_q | axi.rresp[1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
